// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_MEM_WAIT,
    ST_ERROR
  } ctrl_state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use detector: the load in EX writes a register the instruction in ID reads.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  output logic             load_use
);

  // x0 is hardwired to zero, so a load targeting it never creates a dependency
  assign load_use = ex_memread && (ex_rd != REG_ZERO) &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer: arbitrates load-use, taken branches and
// multi-cycle data-memory accesses, and counts stalled cycles.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [REG_W-1:0] id_rs1_i,
  input  logic [REG_W-1:0] id_rs2_i,
  input  logic             ex_memread_i,
  input  logic [REG_W-1:0] ex_rd_i,
  input  logic             branch_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             pc_write_o,
  output logic             if_id_stall_o,
  output logic             if_id_flush_o,
  output logic             id_ex_nop_o,
  output logic             pipe_hold_o,
  output logic             mem_start_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

  ctrl_state_t       state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              load_use;

  hazard_detect u_hazard_detect (
    .ex_memread (ex_memread_i),
    .ex_rd      (ex_rd_i),
    .id_rs1     (id_rs1_i),
    .id_rs2     (id_rs2_i),
    .load_use   (load_use)
  );

  // Holds outrank everything, so a persisting branch flushes only once released
  always_comb begin
    pc_write_o    = 1'b0;
    if_id_stall_o = 1'b0;
    if_id_flush_o = 1'b0;
    id_ex_nop_o   = 1'b0;
    pipe_hold_o   = 1'b0;
    mem_start_o   = 1'b0;
    if (rst_i || (state == ST_ERROR) || !start_i) begin
      if_id_stall_o = 1'b1;
      pipe_hold_o   = 1'b1;
    end else if ((state == ST_MEM_WAIT) && !mem_ack_i) begin
      if_id_stall_o = 1'b1;
      pipe_hold_o   = 1'b1;
    end else if ((state == ST_RUN) && mem_req_i) begin
      if_id_stall_o = 1'b1;
      pipe_hold_o   = 1'b1;
      mem_start_o   = 1'b1;
    end else if (load_use) begin
      if_id_stall_o = 1'b1;
      id_ex_nop_o   = 1'b1;
    end else if (branch_taken_i) begin
      if_id_flush_o = 1'b1;
      pc_write_o    = 1'b1;
    end else begin
      pc_write_o    = 1'b1;
    end
  end

  // The ack cycle returns to RUN without looking at mem_req_i, so a following
  // memory instruction is launched no earlier than the next cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ST_RUN;
      wait_cnt    <= '0;
      err_o       <= 1'b0;
      stall_cnt_o <= '0;
    end else begin
      if (start_i && !pc_write_o && (stall_cnt_o != '1))
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      case (state)
        ST_RUN: begin
          if (mem_start_o) begin
            state    <= ST_MEM_WAIT;
            wait_cnt <= '0;
          end
        end
        ST_MEM_WAIT: begin
          if (mem_ack_i) begin
            state <= ST_RUN;
          end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
            state <= ST_ERROR;
            err_o <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        ST_ERROR: begin
          state <= ST_ERROR;
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table, hand-written
// multi-cycle sequences and a randomized run against a behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int TO    = 4;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk;
  logic          rst, start;
  logic [4:0]    rs1, rs2, exRd;
  logic          exMemread, branch, memReq, memAck;
  logic          pcWrite, ifIdStall, ifIdFlush, idExNop, pipeHold, memStart, err;
  logic [CW-1:0] stallCnt;
  logic [6:0]    outs;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  bit mWait, mErr;
  int mWaited, mCnt;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .start_i        (start),
    .id_rs1_i       (rs1),
    .id_rs2_i       (rs2),
    .ex_memread_i   (exMemread),
    .ex_rd_i        (exRd),
    .branch_taken_i (branch),
    .mem_req_i      (memReq),
    .mem_ack_i      (memAck),
    .pc_write_o     (pcWrite),
    .if_id_stall_o  (ifIdStall),
    .if_id_flush_o  (ifIdFlush),
    .id_ex_nop_o    (idExNop),
    .pipe_hold_o    (pipeHold),
    .mem_start_o    (memStart),
    .err_o          (err),
    .stall_cnt_o    (stallCnt)
  );

  assign outs = {pcWrite, ifIdStall, ifIdFlush, idExNop, pipeHold, memStart, err};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       start;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       memread;
    logic       branch;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[10];

  // {pc_write, if_id_stall, if_id_flush, id_ex_nop, pipe_hold, mem_start, err}
  function automatic logic [6:0] modelOuts();
    bit lu;
    lu = exMemread && (exRd != 5'd0) && ((exRd == rs1) || (exRd == rs2));
    if (rst || mErr || !start)        return {6'b010010, mErr};
    if (mWait && !memAck)             return {6'b010010, mErr};
    if (!mWait && memReq)             return {6'b010011, mErr};
    if (lu)                           return {6'b010100, mErr};
    if (branch)                       return {6'b101000, mErr};
    return {6'b100000, mErr};
  endfunction

  task automatic modelStep();
    logic [6:0] o;
    o = modelOuts();
    if (rst) begin
      mWait = 0; mErr = 0; mWaited = 0; mCnt = 0;
      return;
    end
    if (start && !o[6]) mCnt = (mCnt < CMAX) ? mCnt + 1 : CMAX;
    if (mErr) begin
      // only reset leaves the error state
    end else if (mWait) begin
      if (memAck) mWait = 0;
      else begin
        mWaited++;
        if (mWaited == TO) begin
          mErr  = 1;
          mWait = 0;
        end
      end
    end else if (o[1]) begin
      mWait   = 1;
      mWaited = 0;
    end
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic [4:0] a,
                               input logic [4:0] b, input logic [4:0] d,
                               input logic mr, input logic br, input logic rq,
                               input logic ak);
    rst = r; start = s; rs1 = a; rs2 = b; exRd = d;
    exMemread = mr; branch = br; memReq = rq; memAck = ak;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act,
                             input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic idle(input logic rq, input logic ak, input logic br);
    applyStimulus(1'b0, 1'b1, 5'd1, 5'd2, 5'd3, 1'b0, br, rq, ak);
    #2;
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  initial begin
    vecs[0] = '{1'b1, 5'd1,  5'd2,  5'd5,  1'b0, 1'b0, 7'b1000000};
    vecs[1] = '{1'b1, 5'd1,  5'd5,  5'd5,  1'b1, 1'b0, 7'b0101000};
    vecs[2] = '{1'b1, 5'd0,  5'd0,  5'd0,  1'b1, 1'b0, 7'b1000000};
    vecs[3] = '{1'b1, 5'd7,  5'd3,  5'd7,  1'b1, 1'b0, 7'b0101000};
    vecs[4] = '{1'b1, 5'd7,  5'd3,  5'd7,  1'b0, 1'b0, 7'b1000000};
    vecs[5] = '{1'b1, 5'd4,  5'd6,  5'd9,  1'b1, 1'b1, 7'b1010000};
    vecs[6] = '{1'b1, 5'd9,  5'd6,  5'd9,  1'b1, 1'b1, 7'b0101000};
    vecs[7] = '{1'b0, 5'd9,  5'd6,  5'd9,  1'b1, 1'b1, 7'b0100100};
    vecs[8] = '{1'b0, 5'd1,  5'd2,  5'd3,  1'b0, 1'b0, 7'b0100100};
    vecs[9] = '{1'b1, 5'd2,  5'd31, 5'd31, 1'b1, 1'b0, 7'b0101000};

    mWait = 0; mErr = 0; mWaited = 0; mCnt = 0;

    // reset state
    doReset();
    idle(1'b0, 1'b0, 1'b0);
    checkOutput("reset outs", 16'(outs), 16'(7'b1000000));
    checkOutput("reset cnt", 16'(stallCnt), 16'd0);

    // combinational vector table (all in RUN)
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, vecs[i].start, vecs[i].rs1, vecs[i].rs2, vecs[i].rd,
                    vecs[i].memread, vecs[i].branch, 1'b0, 1'b0);
      #2;
      checkOutput($sformatf("vec%0d", i), 16'(outs), 16'(vecs[i].exp));
      tick();
    end

    // load-use lasts one cycle once the bubble has moved the load on
    doReset();
    applyStimulus(1'b0, 1'b1, 5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    #2 checkOutput("lu stall", 16'(outs), 16'(7'b0101000));
    tick();
    applyStimulus(1'b0, 1'b1, 5'd1, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 checkOutput("lu release", 16'(outs), 16'(7'b1000000));
    checkOutput("lu cnt", 16'(stallCnt), 16'd1);
    tick();

    // memory access, ack three cycles after the request
    doReset();
    idle(1'b1, 1'b0, 1'b0); checkOutput("mem c0", 16'(outs), 16'(7'b0100110)); tick();
    idle(1'b1, 1'b0, 1'b0); checkOutput("mem c1", 16'(outs), 16'(7'b0100100)); tick();
    idle(1'b1, 1'b0, 1'b0); checkOutput("mem c2", 16'(outs), 16'(7'b0100100)); tick();
    idle(1'b1, 1'b1, 1'b0); checkOutput("mem ack", 16'(outs), 16'(7'b1000000)); tick();
    idle(1'b0, 1'b0, 1'b0); checkOutput("mem after", 16'(outs), 16'(7'b1000000));
    checkOutput("mem cnt", 16'(stallCnt), 16'd3);
    tick();

    // branch held through a memory wait, then back-to-back two-cycle access
    doReset();
    idle(1'b1, 1'b0, 1'b1); checkOutput("br c0", 16'(outs), 16'(7'b0100110)); tick();
    idle(1'b1, 1'b0, 1'b1); checkOutput("br c1", 16'(outs), 16'(7'b0100100)); tick();
    idle(1'b1, 1'b0, 1'b1); checkOutput("br c2", 16'(outs), 16'(7'b0100100)); tick();
    idle(1'b1, 1'b1, 1'b1); checkOutput("br ack", 16'(outs), 16'(7'b1010000)); tick();
    idle(1'b1, 1'b0, 1'b0); checkOutput("b2b start", 16'(outs), 16'(7'b0100110)); tick();
    idle(1'b1, 1'b1, 1'b0); checkOutput("b2b ack", 16'(outs), 16'(7'b1000000)); tick();

    // timeout into ERROR, ack ignored there, reset recovers
    doReset();
    idle(1'b1, 1'b0, 1'b0); checkOutput("to start", 16'(outs), 16'(7'b0100110)); tick();
    for (int i = 0; i < TO; i++) begin
      idle(1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("to wait%0d", i), 16'(outs), 16'(7'b0100100));
      tick();
    end
    idle(1'b0, 1'b1, 1'b0); checkOutput("to err ack", 16'(outs), 16'(7'b0100101)); tick();
    idle(1'b0, 1'b0, 1'b0); checkOutput("to err sticky", 16'(outs), 16'(7'b0100101));
    applyStimulus(1'b1, 1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 checkOutput("to in reset", 16'(outs), 16'(7'b0100101));
    tick();
    idle(1'b0, 1'b0, 1'b0); checkOutput("to recovered", 16'(outs), 16'(7'b1000000));
    checkOutput("to cnt", 16'(stallCnt), 16'd0);
    tick();

    // reset mid-access: a late ack is ignored
    doReset();
    idle(1'b1, 1'b0, 1'b0); tick();
    idle(1'b1, 1'b0, 1'b0); tick();
    doReset();
    idle(1'b0, 1'b1, 1'b0); checkOutput("late ack", 16'(outs), 16'(7'b1000000)); tick();
    idle(1'b0, 1'b0, 1'b0); checkOutput("late ack next", 16'(outs), 16'(7'b1000000)); tick();

    // start gating
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
      #2 checkOutput("nostart outs", 16'(outs), 16'(7'b0100100));
      checkOutput("nostart cnt", 16'(stallCnt), 16'd0);
      tick();
    end
    idle(1'b0, 1'b0, 1'b0); checkOutput("start rise", 16'(outs), 16'(7'b1000000)); tick();

    // counter saturation over 20 held cycles
    doReset();
    for (int i = 0; i < 20; i++) begin
      idle(1'b1, 1'b0, 1'b0);
      tick();
    end
    idle(1'b0, 1'b0, 1'b0);
    checkOutput("sat cnt", 16'(stallCnt), 16'(CMAX));
    tick();
    idle(1'b0, 1'b0, 1'b0);
    checkOutput("sat no wrap", 16'(stallCnt), 16'(CMAX));
    tick();

    // randomized run against the behavioural model
    doReset();
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 39) == 0,
                    mWait ? 1'b1 : ($urandom_range(0, 9) != 0),
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                    $urandom_range(0, 2) == 0);
      #2;
      checkOutput("rand outs", 16'(outs), 16'(modelOuts()));
      checkOutput("rand cnt", 16'(stallCnt), 16'(mCnt));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
